// File: rtl/arb_mux_pkg.sv
// Shared types, width helper and reset values for the arbitrated N-channel mux.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb_mux_pkg;

    // Lock state of the output port when multi-beat locking is built in.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Channel-index width: at least one bit, so a single-channel build still
    // has a legal out_ch port.
    function automatic int chw_f(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    localparam logic        RST_OUT_VALID  = 1'b0;
    localparam logic        RST_DATA_BIT   = 1'b0;
    localparam int          RST_CH         = 0;
    localparam int          RST_PTR        = 0;
    localparam lock_state_t RST_LOCK_STATE = UNLOCKED;

endpackage

// File: rtl/arb_mux_nch_rr_arbiter.sv
// Combinational CH-way round-robin picker: first requester at or after ptr wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; grant is one-hot or all-zero when nothing requests.
//
// Ports: req  - per-channel request
//        ptr  - channel with highest priority this cycle (must be < CH)
//        grant- one-hot winner, zero when req is zero
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int CH  = 4,
    parameter int CHW = chw_f(CH)
) (
    input  logic [CH-1:0]  req,
    input  logic [CHW-1:0] ptr,
    output logic [CH-1:0]  grant
);

    int   idx;
    logic found;

    // Walk offsets 0..CH-1 from ptr; the inner loop compares against the
    // wrapped index rather than indexing with it, so a non-power-of-two CH
    // never reaches a slot beyond CH-1.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= CH) begin
                idx = idx - CH;
            end
            for (int c = 0; c < CH; c++) begin
                if (c == idx && req[c] && !found) begin
                    grant[c] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arb_mux_nch.sv
// Round-robin arbitrated CH-to-1 mux into a single registered output stage.
// Latency: 1 cycle from input handshake to out_valid.
// Backpressure: in_ready only when the output register is empty or draining; losers held off.
//
// Optional feature macro: ARB_MUX_LOCK_EN adds in_lock and a lock FSM so one
// channel can own the output for a multi-beat burst.
// Ports: clk/rst_n (async active-low), in_valid/in_data/in_ready per channel
//        (channel c at in_data[c*N +: N]), in_lock (lock builds only),
//        out_valid/out_data/out_ch/out_ready registered output handshake.
module arb_mux_nch
    import arb_mux_pkg::*;
#(
    parameter  int N   = 64,
    parameter  int CH  = 4,
    localparam int CHW = chw_f(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   in_valid,
    input  logic [CH*N-1:0] in_data,
`ifdef ARB_MUX_LOCK_EN
    input  logic [CH-1:0]   in_lock,
`endif
    output logic [CH-1:0]   in_ready,
    output logic            out_valid,
    output logic [N-1:0]    out_data,
    output logic [CHW-1:0]  out_ch,
    input  logic            out_ready
);

    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_data_q,  out_data_d;
    logic [CHW-1:0] out_ch_q,    out_ch_d;
    logic [CHW-1:0] ptr_q,       ptr_d;

    logic           load_en;
    logic           xfer;
    logic           ptr_adv;
    logic [CH-1:0]  req;
    logic [CH-1:0]  grant;
    logic [CHW-1:0] g_idx;
    logic [CHW-1:0] g_next;
    logic [N-1:0]   sel_data;

    assign load_en = !out_valid_q | out_ready;

    rr_arbiter #(
        .CH  (CH),
        .CHW (CHW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // rst_n gating keeps in_ready low while reset is held, even though the
    // empty output register would otherwise advertise space.
    assign in_ready = grant & {CH{load_en & rst_n}};
    assign xfer     = |(in_valid & in_ready);

    // Encode the winner and steer its data; grant is one-hot so at most one
    // iteration fires.
    always_comb begin
        g_idx    = '0;
        sel_data = '0;
        for (int c = 0; c < CH; c++) begin
            if (grant[c]) begin
                g_idx    = CHW'(c);
                sel_data = in_data[c*N +: N];
            end
        end
    end

    assign g_next = (g_idx == CHW'(CH - 1)) ? '0 : g_idx + CHW'(1);

`ifdef ARB_MUX_LOCK_EN
    lock_state_t    state_q, state_d;
    logic [CHW-1:0] owner_q, owner_d;
    logic           sel_lock;

    assign sel_lock = |(in_lock & grant);

    // While locked, only the owner may request; if it drops valid the port
    // simply stalls.
    always_comb begin
        req = in_valid;
        if (state_q == LOCKED) begin
            for (int c = 0; c < CH; c++) begin
                req[c] = in_valid[c] && (CHW'(c) == owner_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (xfer) begin
            case (state_q)
                UNLOCKED: begin
                    if (sel_lock) begin
                        state_d = LOCKED;
                        owner_d = g_idx;
                    end
                end
                LOCKED: begin
                    if (!sel_lock) begin
                        state_d = UNLOCKED;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_LOCK_STATE;
            owner_q <= CHW'(RST_CH);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Mid-burst beats leave ptr frozen; the closing beat moves it past the owner.
    assign ptr_adv = !((state_q == LOCKED) && sel_lock);
`else
    assign req     = in_valid;
    assign ptr_adv = 1'b1;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            // A draining beat and a new load in one cycle: overwrite, no bubble.
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = g_idx;
            if (ptr_adv) begin
                ptr_d = g_next;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= RST_OUT_VALID;
            out_data_q  <= {N{RST_DATA_BIT}};
            out_ch_q    <= CHW'(RST_CH);
            ptr_q       <= CHW'(RST_PTR);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux_nch.sv
// Bench for arb_mux_nch: a CH=4 and a CH=3 instance with a queue scoreboard.
// Latency: n/a.
// Backpressure: driven by the bench through out_ready.
module tb_arb_mux_nch;

    typedef struct packed {
        logic [1:0]  ch;
        logic [63:0] dat;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;

    logic [3:0]     v4 = '0;
    logic [255:0]   d4;
    logic [3:0]     r4;
    logic           ov4;
    logic [63:0]    od4;
    logic [1:0]     oc4;
    logic           ordy4 = 1'b1;

    logic [2:0]     v3 = '0;
    logic [191:0]   d3;
    logic [2:0]     r3;
    logic           ov3;
    logic [63:0]    od3;
    logic [1:0]     oc3;
    logic           ordy3 = 1'b1;

`ifdef ARB_MUX_LOCK_EN
    logic [3:0]     l4 = '0;
    logic [2:0]     l3 = '0;
`endif

    beat_t q4[$];
    beat_t q3[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    arb_mux_nch #(.N(64), .CH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4),
        .in_data   (d4),
`ifdef ARB_MUX_LOCK_EN
        .in_lock   (l4),
`endif
        .in_ready  (r4),
        .out_valid (ov4),
        .out_data  (od4),
        .out_ch    (oc4),
        .out_ready (ordy4)
    );

    arb_mux_nch #(.N(64), .CH(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v3),
        .in_data   (d3),
`ifdef ARB_MUX_LOCK_EN
        .in_lock   (l3),
`endif
        .in_ready  (r3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_ch    (oc3),
        .out_ready (ordy3)
    );

    function automatic logic [63:0] dat4(input int c);
        return 64'hC0DE_0000_0000_0000 | 64'(c);
    endfunction

    function automatic logic [63:0] dat3(input int c);
        return 64'hA3A3_0000_0000_0000 | 64'(c);
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push4(input int c);
        beat_t b;
        b.ch  = 2'(c);
        b.dat = dat4(c);
        q4.push_back(b);
    endtask

    task automatic push3(input int c);
        beat_t b;
        b.ch  = 2'(c);
        b.dat = dat3(c);
        q3.push_back(b);
    endtask

    initial begin
        for (int c = 0; c < 4; c++) d4[c*64 +: 64] = dat4(c);
        for (int c = 0; c < 3; c++) d3[c*64 +: 64] = dat3(c);

        fork
            // Monitor: every accepted output beat is popped and compared.
            begin
                beat_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && ov4 && ordy4) begin
                        if (q4.size() == 0) begin
                            n_cmp++; n_err++;
                            $display("FAIL sb4 unexpected beat: got ch %0d data %h, none required", oc4, od4);
                        end else begin
                            e = q4.pop_front();
                            check("sb4 beat {ch,data}", {6'b0, oc4, od4}, {6'b0, e.ch, e.dat});
                        end
                    end
                    if (rst_n && ov3 && ordy3) begin
                        if (q3.size() == 0) begin
                            n_cmp++; n_err++;
                            $display("FAIL sb3 unexpected beat: got ch %0d data %h, none required", oc3, od3);
                        end else begin
                            e = q3.pop_front();
                            check("sb3 beat {ch,data}", {6'b0, oc3, od3}, {6'b0, e.ch, e.dat});
                        end
                    end
                end
            end

            // Stimulus
            begin
                // Reset held with every channel requesting.
                #2 rst_n = 1'b0;
                v4 = 4'hF;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("reset out_valid", 72'(ov4), 72'(0));
                check("reset out_data", 72'(od4), 72'(0));
                check("reset out_ch", 72'(oc4), 72'(0));
                check("reset in_ready4", 72'(r4), 72'(0));
                check("reset in_ready3", 72'(r3), 72'(0));

                // Fairness: 0,1,2,3,0,1 one per cycle.
                for (int i = 0; i < 6; i++) push4(i % 4);
                @(posedge clk); #1 rst_n = 1'b1;
                @(negedge clk);
                check("latency out_valid before edge", 72'(ov4), 72'(0));
                check("first grant ch0 in_ready", 72'(r4), 72'(4'b0001));
                repeat (6) @(posedge clk);
                #1 v4 = 4'h0;

                // Back-pressure: ch2 held three cycles, ch3 loads on release.
                push4(2); push4(3);
                @(posedge clk); #1 v4 = 4'hF; ordy4 = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("bp held data", 72'(od4), 72'(dat4(2)));
                    check("bp in_ready low", 72'(r4), 72'(0));
                end
                @(posedge clk); #1 ordy4 = 1'b1;
                @(negedge clk);
                check("bp release in_ready ch3", 72'(r4), 72'(4'b1000));
                @(posedge clk); #1 v4 = 4'h0;

                // CH=3 wrap: prime ptr with ch1, then only 2 and 0 valid.
                push3(1);
                @(posedge clk); #1 v3 = 3'b010;
                push3(2); push3(0); push3(2); push3(0);
                @(posedge clk); #1 v3 = 3'b101;
                repeat (4) @(posedge clk);
                #1 v3 = 3'b000;

`ifdef ARB_MUX_LOCK_EN
                // Locked burst from ch1 while 0,2,3 also request.
                push4(0);
                @(posedge clk); #1 v4 = 4'b0001; l4 = 4'b0000;
                push4(1); push4(1); push4(1); push4(1); push4(2);
                @(posedge clk); #1 v4 = 4'hF; l4 = 4'b0010;
                @(posedge clk); #1;
                @(negedge clk);
                check("locked only owner ready", 72'(r4), 72'(4'b0010));
                @(posedge clk); #1;
                @(posedge clk); #1 l4 = 4'b0000;
                @(posedge clk); #1;
                @(posedge clk); #1 v4 = 4'h0;

                // Owner drops valid mid-burst: stall, nobody else granted.
                push4(0);
                @(posedge clk); #1 v4 = 4'b0001; l4 = 4'b0000;
                push4(1);
                @(posedge clk); #1 v4 = 4'hF; l4 = 4'b0010;
                @(posedge clk); #1 v4 = 4'b1101;
                @(negedge clk);
                check("lock stall in_ready", 72'(r4), 72'(0));
                @(posedge clk); #1;
                @(negedge clk);
                check("lock stall in_ready 2", 72'(r4), 72'(0));
                push4(1); push4(2);
                @(posedge clk); #1 v4 = 4'hF; l4 = 4'b0000;
                @(posedge clk); #1;
                @(posedge clk); #1 v4 = 4'h0;
`endif

                // Reset while a beat is held (locked to ch1 in lock builds).
                @(posedge clk); #1 v4 = 4'b0010; ordy4 = 1'b0;
`ifdef ARB_MUX_LOCK_EN
                l4 = 4'b0010;
`endif
                @(posedge clk); #1 v4 = 4'h0;
                #3 rst_n = 1'b0;
                #1;
                check("async reset out_valid", 72'(ov4), 72'(0));
                check("async reset out_ch", 72'(oc4), 72'(0));
                push4(0);
                @(posedge clk); #1 rst_n = 1'b1; v4 = 4'hF; ordy4 = 1'b1;
`ifdef ARB_MUX_LOCK_EN
                l4 = 4'b0000;
`endif
                @(negedge clk);
                check("post reset grant ch0", 72'(r4), 72'(4'b0001));
                @(posedge clk); #1 v4 = 4'h0;

                repeat (3) @(posedge clk);
                @(negedge clk);
                check("sb4 leftover beats", 72'(q4.size()), 72'(0));
                check("sb3 leftover beats", 72'(q3.size()), 72'(0));
            end
        join_any
        disable fork;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
